// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and types for the SPI-style frame receiver
package spi_pkg;

    localparam logic [7:0] HDR_START = 8'hA5;
    localparam logic [7:0] HDR_CFG   = 8'h3C;
    localparam logic [7:0] HDR_READ  = 8'h5A;

    localparam int CFG_LEN  = 8;
    localparam int READ_LEN = 10;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_CFG   = 2'd1,
        CMD_READ  = 2'd2
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_WAIT_LOW
    } state_e;

endpackage

// File: rtl/spi_susp_mon.sv
// rtl/spi_susp_mon.sv - counts consecutive suspend clocks, one pulse per run reaching SUSP_MAX
module spi_susp_mon #(
    parameter int SUSP_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic suspend,
    output logic susp_err
);

    localparam int W = $clog2(SUSP_MAX + 1);

    logic [W-1:0] run_q, run_d;
    logic         pulse_q, pulse_d;

    // The counter saturates at SUSP_MAX so a long run pulses only once.
    always_comb begin
        run_d   = run_q;
        pulse_d = 1'b0;
        if (!suspend) begin
            run_d = '0;
        end else if (run_q != W'(SUSP_MAX)) begin
            run_d   = run_q + W'(1);
            pulse_d = (run_d == W'(SUSP_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            pulse_q <= pulse_d;
        end
    end

    assign susp_err = pulse_q;

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - slave-side frame receiver: header capture, length check, command report
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int SUSP_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       serial,
    input  logic       suspend,
    output logic       cmd_valid,
    output logic [1:0] cmd,
    output logic [7:0] cfg_data,
    output logic       error,
    output logic       susp_err
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  sh_q, sh_d;
    cmd_e        kind_q, kind_d;
    cmd_e        cmd_q, cmd_d;
    logic [7:0]  cfg_q, cfg_d;
    logic        frame_q, primed_q;
    logic        cmd_valid_q, error_q;
    logic        done, err;
    logic [3:0]  len;

    assign len = (kind_q == CMD_CFG) ? 4'(CFG_LEN) : 4'(READ_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hdr_d   = hdr_q;
        sh_d    = sh_q;
        kind_d  = kind_q;
        cmd_d   = cmd_q;
        cfg_d   = cfg_q;
        done    = 1'b0;
        err     = 1'b0;
        if (!suspend) begin
            case (state_q)
                ST_IDLE: begin
                    // primed_q keeps a frame already high at reset release from looking like a rise
                    if (frame && !frame_q && primed_q) begin
                        state_d = ST_HDR;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HDR: begin
                    if (cnt_q != 4'd8) begin
                        if (!frame) begin
                            err = 1'b1;
                        end else begin
                            hdr_d[cnt_q[2:0]] = serial;
                            cnt_d             = cnt_q + 4'd1;
                        end
                    end else begin
                        case (hdr_q)
                            HDR_START: begin
                                if (frame) begin
                                    err = 1'b1;
                                end else begin
                                    done  = 1'b1;
                                    cmd_d = CMD_START;
                                end
                            end
                            HDR_CFG, HDR_READ: begin
                                // The decode edge doubles as payload cycle 1.
                                if (!frame) begin
                                    err = 1'b1;
                                end else begin
                                    kind_d  = (hdr_q == HDR_CFG) ? CMD_CFG : CMD_READ;
                                    state_d = ST_PAYLOAD;
                                    cnt_d   = 4'd1;
                                    sh_d    = {serial, sh_q[7:1]};
                                end
                            end
                            default: err = 1'b1;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q != len) begin
                        if (!frame) begin
                            err = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                            sh_d  = {serial, sh_q[7:1]};
                        end
                    end else if (frame) begin
                        err = 1'b1;
                    end else begin
                        done  = 1'b1;
                        cmd_d = kind_q;
                        if (kind_q == CMD_CFG) begin
                            cfg_d = sh_q;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (!frame) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (done) begin
                state_d = ST_IDLE;
            end
            if (err) begin
                state_d = frame ? ST_WAIT_LOW : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hdr_q       <= 8'd0;
            sh_q        <= 8'd0;
            kind_q      <= CMD_START;
            cmd_q       <= CMD_START;
            cfg_q       <= 8'd0;
            frame_q     <= 1'b0;
            primed_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            sh_q        <= sh_d;
            kind_q      <= kind_d;
            cmd_q       <= cmd_d;
            cfg_q       <= cfg_d;
            cmd_valid_q <= done;
            error_q     <= err;
            if (!suspend) begin
                frame_q  <= frame;
                primed_q <= 1'b1;
            end
        end
    end

    spi_susp_mon #(.SUSP_MAX(SUSP_MAX)) u_susp_mon (
        .clk      (clk),
        .rst      (rst),
        .suspend  (suspend),
        .susp_err (susp_err)
    );

    assign cmd_valid = cmd_valid_q;
    assign cmd       = cmd_q;
    assign cfg_data  = cfg_q;
    assign error     = error_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed frame-level bench with an outcome model for spi_frame_rx
module tb_spi_frame_rx;

    localparam int SUSP_MAX = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame = 1'b0;
    logic       serial = 1'b0;
    logic       suspend = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic [7:0] cfg_data;
    logic       error;
    logic       susp_err;

    spi_frame_rx #(.SUSP_MAX(SUSP_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .serial    (serial),
        .suspend   (suspend),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cfg_data  (cfg_data),
        .error     (error),
        .susp_err  (susp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic       exp_valid = 1'b0;
    logic       exp_error = 1'b0;
    logic       exp_susp  = 1'b0;
    logic [1:0] exp_cmd   = 2'd0;
    logic [7:0] exp_cfg   = 8'd0;
    int run = 0;
    int cnt_v = 0, cnt_e = 0, cnt_s = 0;
    int mark_v = 0, mark_e = 0, mark_s = 0;
    logic [63:0] sm;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmd_valid", {7'd0, cmd_valid}, {7'd0, exp_valid});
        chk("error", {7'd0, error}, {7'd0, exp_error});
        chk("susp_err", {7'd0, susp_err}, {7'd0, exp_susp});
        chk("cfg_data", cfg_data, exp_cfg);
        if (exp_valid) chk("cmd", {6'd0, cmd}, {6'd0, exp_cmd});
        cnt_v += int'(cmd_valid);
        cnt_e += int'(error);
        cnt_s += int'(susp_err);
    end

    task automatic step(input logic f, input logic s, input logic sp, input logic ev_v, input logic ev_e);
        frame   = f;
        serial  = s;
        suspend = sp;
        @(posedge clk);
        #1;
        run       = sp ? run + 1 : 0;
        exp_susp  = (run == SUSP_MAX);
        exp_valid = ev_v;
        exp_error = ev_e;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        suspend   = 1'b0;
        exp_valid = 1'b0;
        exp_error = 1'b0;
        exp_susp  = 1'b0;
        exp_cfg   = 8'd0;
        exp_cmd   = 2'd0;
        run       = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Frame shape: frame high for enabled edges 0..h-1, low from edge h on.
    // Outcome is decided at edge min(h, 9+payload_len); legal only when h == 9+payload_len.
    task automatic send_frame(input logic [7:0] hdr, input int h, input logic [7:0] pay,
                              input logic [63:0] smask, input int tail, input int abort_at);
        int  n, e;
        bit  legal, ok;
        logic s;
        n     = (hdr == 8'h3C) ? 8 : (hdr == 8'h5A) ? 10 : 0;
        legal = (hdr == 8'hA5) || (hdr == 8'h3C) || (hdr == 8'h5A);
        e     = (h < 9) ? h : ((h < 9 + n) ? h : 9 + n);
        ok    = legal && (h == 9 + n);
        for (int i = 0; i <= h + tail; i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            for (int k = 0; k < int'(smask[2*i +: 2]); k++)
                step(i < h, 1'($urandom), 1'b1, 1'b0, 1'b0);
            if (i >= 1 && i <= 8)       s = hdr[i-1];
            else if (i >= 9 && i <= 16) s = pay[i-9];
            else                        s = 1'($urandom);
            step(i < h, s, 1'b0, ok && (i == e), !ok && (i == e));
            if (ok && i == e) begin
                exp_cmd = (n == 8) ? 2'd1 : (n == 10) ? 2'd2 : 2'd0;
                if (n == 8) exp_cfg = pay;
            end
        end
    endtask

    task automatic expect_counts(input string name, input int dv, input int de, input int ds);
        @(negedge clk);
        #1;
        chk({name, "_valids"}, 8'(cnt_v - mark_v), 8'(dv));
        chk({name, "_errors"}, 8'(cnt_e - mark_e), 8'(de));
        chk({name, "_susps"},  8'(cnt_s - mark_s), 8'(ds));
        mark_v = cnt_v;
        mark_e = cnt_e;
        mark_s = cnt_s;
    endtask

    initial begin
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_counts("reset", 0, 0, 0);

        send_frame(8'hA5, 9, 8'h00, 64'd0, 2, -1);
        expect_counts("start", 1, 0, 0);
        chk("start_cmd_lit", {6'd0, cmd}, 8'd0);

        sm = '0;
        sm[2*3 +: 2]  = 2'd1;
        sm[2*10 +: 2] = 2'd2;
        sm[2*15 +: 2] = 2'd3;
        sm[2*18 +: 2] = 2'd3;
        send_frame(8'h3C, 17, 8'hC3, sm, 2, -1);
        expect_counts("cfg", 1, 0, 0);
        chk("cfg_lit", cfg_data, 8'hC3);
        chk("cfg_cmd_lit", {6'd0, cmd}, 8'd1);

        send_frame(8'h5A, 19, 8'h00, 64'd0, 0, -1);
        send_frame(8'h5A, 18, 8'h00, 64'd0, 2, -1);
        expect_counts("read", 1, 1, 0);
        chk("read_cmd_lit", {6'd0, cmd}, 8'd2);

        send_frame(8'h00, 14, 8'h00, 64'd0, 2, -1);
        send_frame(8'hA5, 5, 8'h00, 64'd0, 2, -1);
        expect_counts("bad_hdr", 0, 2, 0);

        send_frame(8'h3C, 9, 8'hFF, 64'd0, 1, -1);
        send_frame(8'hA5, 12, 8'h00, 64'd0, 1, -1);
        send_frame(8'h3C, 20, 8'h0F, 64'd0, 2, -1);
        expect_counts("length", 0, 3, 0);
        chk("cfg_hold_lit", cfg_data, 8'hC3);

        repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_counts("suspend", 0, 0, 2);

        send_frame(8'h3C, 17, 8'h99, 64'd0, 0, 12);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_counts("abort", 0, 0, 0);
        chk("abort_cfg_lit", cfg_data, 8'h00);
        send_frame(8'hA5, 9, 8'h00, 64'd0, 2, -1);
        expect_counts("post_reset", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
